// File: rtl/lander_core.sv
// Lunar-lander physics core: BCD altitude/velocity/fuel/thrust with FLY/LANDED/CRASHED FSM.
// Optional macro LANDER_MAG_EN: velocity display shows sign+magnitude instead of ten's complement.
module lander_core #(
    parameter logic [15:0] ALT_INIT    = 16'h4500,
    parameter logic [15:0] VEL_INIT    = 16'h0000,
    parameter logic [15:0] FUEL_INIT   = 16'h0800,
    parameter logic [15:0] THRUST_INIT = 16'h0005,
    parameter logic [15:0] GRAVITY     = 16'h0005
) (
    input  logic        hz100,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        key_valid,
    input  logic [3:0]  key,
    input  logic [1:0]  disp_sel,
    output logic [15:0] disp,
    output logic        disp_neg,
    output logic        land,
    output logic        crash
);
    typedef enum logic [1:0] {FLY, LANDED, CRASHED} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_alt, r_vel, r_fuel;
    logic [3:0]  r_thrust;
    logic [15:0] w_alt_nxt, w_vel_nxt, w_fuel_nxt;
    logic [3:0]  w_thrust_nxt;

    // Per-digit decimal add; carry out of the top digit is dropped (mod 10000).
    function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        logic [15:0] s;
        logic [4:0]  d;
        logic        c;
        s = '0;
        c = cin;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = d[3:0];
        end
        return s;
    endfunction

    function automatic logic [15:0] bcd_sub(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] n;
        for (int i = 0; i < 4; i++) n[4*i +: 4] = 4'd9 - b[4*i +: 4];
        return bcd_add(a, n, 1'b1);
    endfunction

    logic [15:0] w_thr16, w_eff, w_alt_sum, w_vel_sum, w_fuel_sub;
    logic        w_ground, w_soft;

    // BCD ordering matches binary ordering, so plain compares are decimal-correct.
    assign w_thr16    = {12'h000, r_thrust};
    assign w_eff      = (r_fuel < w_thr16) ? r_fuel : w_thr16;
    assign w_alt_sum  = bcd_add(r_alt, r_vel, 1'b0);
    assign w_vel_sum  = bcd_sub(bcd_add(r_vel, w_eff, 1'b0), GRAVITY);
    assign w_fuel_sub = bcd_sub(r_fuel, w_eff);
    assign w_ground   = (w_alt_sum == 16'h0000) || (w_alt_sum >= 16'h5000);
    assign w_soft     = (w_vel_sum < 16'h5000) || (w_vel_sum >= 16'h9970);

    always_ff @(posedge hz100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FLY;
            r_alt    <= ALT_INIT;
            r_vel    <= VEL_INIT;
            r_fuel   <= FUEL_INIT;
            r_thrust <= THRUST_INIT[3:0];
        end else begin
            r_state  <= w_state_nxt;
            r_alt    <= w_alt_nxt;
            r_vel    <= w_vel_nxt;
            r_fuel   <= w_fuel_nxt;
            r_thrust <= w_thrust_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_alt_nxt    = r_alt;
        w_vel_nxt    = r_vel;
        w_fuel_nxt   = r_fuel;
        w_thrust_nxt = r_thrust;
        if (r_state == FLY) begin
            if (key_valid && (key <= 4'd9))
                w_thrust_nxt = key;
            if (tick) begin
                w_fuel_nxt = w_fuel_sub;
                if (w_ground) begin
                    w_alt_nxt   = 16'h0000;
                    w_vel_nxt   = 16'h0000;
                    w_state_nxt = w_soft ? LANDED : CRASHED;
                end else begin
                    w_alt_nxt = w_alt_sum;
                    w_vel_nxt = w_vel_sum;
                end
            end
        end
    end

    assign land  = (r_state == LANDED);
    assign crash = (r_state == CRASHED);

    logic [15:0] w_raw;
    always_comb begin
        case (disp_sel)
            2'd0:    w_raw = r_alt;
            2'd1:    w_raw = r_vel;
            2'd2:    w_raw = r_fuel;
            default: w_raw = w_thr16;
        endcase
    end

`ifdef LANDER_MAG_EN
    logic w_vel_neg;
    assign w_vel_neg = (disp_sel == 2'd1) && (r_vel >= 16'h5000);
    assign disp      = w_vel_neg ? bcd_sub(16'h0000, r_vel) : w_raw;
    assign disp_neg  = w_vel_neg;
`else
    assign disp      = w_raw;
    assign disp_neg  = 1'b0;
`endif

endmodule

// File: doc/lander_core.md
LANDER_CORE -- requirements
Module: lander_core

Interface
REQ-001 Parameter ALT_INIT, 16'h4500, initial altitude, 4-digit BCD.
REQ-002 Parameter VEL_INIT, 16'h0000, initial velocity, 4-digit BCD ten's complement.
REQ-003 Parameter FUEL_INIT, 16'h0800, initial fuel, 4-digit BCD.
REQ-004 Parameter THRUST_INIT, 16'h0005, initial thrust, BCD, 0-9.
REQ-005 Parameter GRAVITY, 16'h0005, velocity decrement per tick, BCD.
REQ-006 hz100  in  1  clock, rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 tick  in  1  one-cycle physics-update strobe.
REQ-009 key_valid  in  1  thrust-key strobe.
REQ-010 key  in  4  thrust digit.
REQ-011 disp_sel  in  2  display select: 0 alt, 1 vel, 2 fuel, 3 thrust.
REQ-012 disp  out  16  selected value, BCD.
REQ-013 disp_neg  out  1  selected value negative.
REQ-014 land  out  1  safe-landing flag.
REQ-015 crash  out  1  crash flag.

Function
REQ-016 The block SHALL have three states: FLY, LANDED, CRASHED; land=1 only in LANDED, crash=1 only in CRASHED.
REQ-017 Signed values SHALL be 4-digit BCD ten's complement; 5000-9999 represent -5000 to -1.
REQ-018 On a rising edge with tick=1 in FLY, the block SHALL set eff=min(thrust,fuel), alt<=alt+vel, vel<=vel+eff-GRAVITY, fuel<=fuel-eff. All updates use pre-edge values.
REQ-019 When fuel<thrust, eff SHALL equal fuel; fuel SHALL reach 0000; thrust register SHALL be unchanged.
REQ-020 If alt+vel is 0000 or negative on a tick, the block SHALL enter LANDED when vel_next>=-30 (9970-9999 or 0000-4999). Otherwise it SHALL enter CRASHED. On either entry alt<=0000 and vel<=0000 on the same edge.
REQ-021 key_valid=1 with key<=9 in FLY SHALL load thrust<=key; key>9 SHALL be ignored.
REQ-022 With key_valid and tick in the same cycle, the tick SHALL use the old thrust, and the new thrust SHALL be loaded on the same edge.
REQ-023 In LANDED/CRASHED, tick and key_valid SHALL be ignored; state holds until reset.
REQ-024 disp SHALL be combinational from registers and disp_sel, with zero latency.
REQ-025 All arithmetic SHALL be decimal-correct per digit; carries out of digit 3 are discarded (mod 10000).

Reset
REQ-026 rst_n=0 SHALL immediately load alt=ALT_INIT, vel=VEL_INIT, fuel=FUEL_INIT, thrust=THRUST_INIT, state=FLY, land=0, crash=0.
REQ-027 Reset asserted mid-flight or after landing/crash SHALL restore the REQ-026 values regardless of tick/key_valid; operation resumes on the first edge after release.

Configuration
REQ-028 Macro LANDER_MAG_EN defined: for disp_sel=1 with negative vel, disp SHALL show magnitude (10000-vel, BCD) and disp_neg=1; otherwise disp_neg=0.
REQ-029 Macro LANDER_MAG_EN undefined: disp SHALL show raw ten's complement; disp_neg SHALL be tied 0.

Verification
REQ-030 Reset, default params -> disp 4500/0000/0800/0005 for sel 0-3, land=0, crash=0.
REQ-031 One tick, thrust 5 -> alt 4500, vel 0000, fuel 0795.
REQ-032 key=0 loaded, three ticks -> vel 9995/9990/9985, alt 4500/4495/4485. With LANDER_MAG_EN: sel=1 shows 0015, disp_neg=1.
REQ-033 ALT_INIT=0020, thrust 0, four ticks -> alt 0020/0015/0005, then LANDED, land=1, alt=vel=0000. Further ticks ignored.
REQ-034 ALT_INIT=0020, VEL_INIT=9950, thrust 0, one tick -> crash=1, alt=vel=0000.
REQ-035 FUEL_INIT=0003, thrust 5, tick with key_valid key=7 -> fuel 0000, vel 9998, thrust 0007. Then rst_n pulse mid-flight -> REQ-026 values.
